// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract sequencer: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell, with a start/busy/done handshake.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, busy_q, busy_d, done_q, done_d, bout_q, bout_d;

  // Shared full-subtractor cell, always fed from the low end of the operand shifters.
  logic abit, bbit, dbit, br_nxt;
  always_comb begin
    abit   = a_q[0];
    bbit   = b_q[0];
    dbit   = abit ^ bbit ^ br_q;
    br_nxt = (~abit & bbit) | (~(abit ^ bbit) & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        br_d           = br_nxt;
        // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_d          = res_q >> 1;
        res_d[WIDTH-1] = dbit;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          diff_d  = res_d;
          bout_d  = br_nxt;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl at WIDTH 8, 4 and 1 against an arithmetic reference
// (a - b - bin with borrow = a < b + bin) and a fixed-latency handshake model.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, st8, st4, st1, bin;
  logic [7:0] a, b;

  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a), .b(b), .bin(bin),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
  serial_sub_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a[3:0]), .b(b[3:0]), .bin(bin),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));
  serial_sub_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a[0:0]), .b(b[0:0]), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

  int         sel = 8;
  logic       cur_busy, cur_done, cur_bout;
  logic [7:0] cur_diff;
  always_comb begin
    cur_busy = busy8; cur_done = done8; cur_bout = bout8; cur_diff = diff8;
    case (sel)
      4: begin cur_busy = busy4; cur_done = done4; cur_bout = bout4; cur_diff = {4'h0, diff4}; end
      1: begin cur_busy = busy1; cur_done = done1; cur_bout = bout1; cur_diff = {7'h0, diff1}; end
      default: ;
    endcase
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_d [0:8];
  logic       last_b [0:8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_st(input int w, input logic v);
    case (w)
      8: st8 = v;
      4: st4 = v;
      default: st1 = v;
    endcase
  endtask

  task automatic clear_last();
    for (int i = 0; i <= 8; i++) begin
      last_d[i] = 8'h00;
      last_b[i] = 1'b0;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after it is idle again,
  // so consecutive calls exercise the maximum issue rate of one op per w+2 cycles.
  task automatic do_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input bit hold);
    int         m, e;
    logic [7:0] mk, ed;
    logic       eb;
    m  = (1 << w) - 1;
    mk = 8'(m);
    e  = int'(av & mk) - int'(bv & mk) - int'(bi);
    ed = 8'(e & m);
    eb = (int'(av & mk) < int'(bv & mk) + int'(bi));
    sel = w;
    a = av; b = bv; bin = bi; set_st(w, 1'b1);
    for (int k = 0; k <= w + 1; k++) begin
      @(negedge clk);
      chk("busy", 32'(cur_busy), 32'(k <= w));
      chk("done", 32'(cur_done), 32'(k == w));
      if (k < w) begin
        chk("diff_hold", 32'(cur_diff), 32'(last_d[w]));
        chk("bout_hold", 32'(cur_bout), 32'(last_b[w]));
      end else begin
        chk("diff", 32'(cur_diff), 32'(ed));
        chk("bout", 32'(cur_bout), 32'(eb));
      end
      if (k == 0) begin
        if (hold) begin
          a = 8'h01; b = 8'h02; bin = 1'b0;
        end else begin
          set_st(w, 1'b0);
          a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        end
      end
    end
    last_d[w] = ed;
    last_b[w] = eb;
  endtask

  initial begin
    rst_n = 1'b0; st8 = 1'b0; st4 = 1'b0; st1 = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    clear_last();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'({busy8, busy4, busy1}), 32'h0);
    chk("rst_done", 32'({done8, done4, done1}), 32'h0);
    chk("rst_diff", 32'({diff8, diff4, diff1}), 32'h0);
    chk("rst_bout", 32'({bout8, bout4, bout1}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, including underflow and borrow-in corners.
    do_op(8, 8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op(8, 8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8, 8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op(8, 8'h10, 8'h0F, 1'b1, 1'b0);

    // start held high through the op; operands change after capture.
    do_op(8, 8'h5A, 8'h3C, 1'b0, 1'b1);
    do_op(8, 8'h01, 8'h02, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an operation.
    a = 8'h5A; b = 8'h3C; bin = 1'b0; st8 = 1'b1; sel = 8;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy8), 32'h0);
    chk("mid_rst_done", 32'(done8), 32'h0);
    chk("mid_rst_diff", 32'(diff8), 32'h0);
    chk("mid_rst_bout", 32'(bout8), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done8), 32'h0);
      chk("post_rst_busy", 32'(busy8), 32'h0);
    end
    clear_last();
    do_op(8, 8'h80, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++)
      do_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int bi = 0; bi < 2; bi++)
          do_op(4, 8'(av), 8'(bv), 1'(bi), 1'b0);

    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int bi = 0; bi < 2; bi++)
          do_op(1, 8'(av), 8'(bv), 1'(bi), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
